// File: rtl/qsys_serial_pkg.sv
// Shared definitions for the Qsys serial link (initiator and serial host):
// frame geometry, FSM states and the timeout response word.
package qsys_serial_pkg;

  localparam int FRAME_BITS = 65;
  localparam int RSP_BITS   = 32;
  localparam int RW_BIT     = 64;
  localparam int ADDR_MSB   = 63;
  localparam int ADDR_LSB   = 32;

  localparam logic [RSP_BITS-1:0] TIMEOUT_DATA = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    WAIT_RSP,
    DONE
  } state_t;

  // Reads carry an all-zero data field so the host sees a fixed frame layout.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic        is_write,
    input logic [31:0] addr,
    input logic [31:0] wdata
  );
    build_frame = {is_write, addr, (is_write ? wdata : 32'h0)};
  endfunction

endpackage

// File: rtl/qsys_serial_initiator_if.sv
// Avalon-MM slave port S1 of the serial initiator, bundled with master/slave views.
interface qsys_serial_initiator_if #(
  parameter int ADDR_WIDTH = 8
) ();

  logic [ADDR_WIDTH-1:0] avs_S1_address;
  logic                  avs_S1_read;
  logic                  avs_S1_write;
  logic [31:0]           avs_S1_writedata;
  logic [31:0]           avs_S1_readdata;
  logic                  avs_S1_waitrequest;

  modport master (
    output avs_S1_address,
    output avs_S1_read,
    output avs_S1_write,
    output avs_S1_writedata,
    input  avs_S1_readdata,
    input  avs_S1_waitrequest
  );

  modport slave (
    input  avs_S1_address,
    input  avs_S1_read,
    input  avs_S1_write,
    input  avs_S1_writedata,
    output avs_S1_readdata,
    output avs_S1_waitrequest
  );

endinterface

// File: rtl/qsys_serial_shift_reg.sv
// Generic left-shifting register with parallel load; the serial input enters at bit 0.
module qsys_serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] shifted;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign shifted[gi] = ser_in;
      end else begin : g_upper
        assign shifted[gi] = q_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= load_data;
    end else if (shift_en) begin
      q_reg <= shifted;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/qsys_serial_initiator.sv
// Avalon-MM slave that tunnels each transfer over the Qsys serial link as a 65-bit
// command frame and waits for a 32-bit response. Optional response timeout: SERIAL_TIMEOUT_EN.
module qsys_serial_initiator
  import qsys_serial_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  qsys_serial_initiator_if.slave  avs,
  output logic                    sdo,
  output logic                    sle,
  input  logic                    sdi,
  input  logic                    srdy
`ifdef SERIAL_TIMEOUT_EN
  ,
  output logic                    timeout_err
`endif
);

  state_t                state_reg;
  logic [6:0]            bit_cnt_reg;
  logic [4:0]            rsp_cnt_reg;
  logic                  sle_reg;
  logic                  sdo_reg;
  logic                  is_read_reg;
  logic [RSP_BITS-1:0]   readdata_reg;

  logic                  req;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [FRAME_BITS-1:0] frame;
  logic                  tx_load;
  logic                  tx_shift;
  logic                  rx_shift;
  logic [FRAME_BITS-1:0] tx_q;
  logic [RSP_BITS-1:0]   rx_q;

  assign req     = avs.avs_S1_read | avs.avs_S1_write;
  assign addr_q  = avs.avs_S1_address;
  // Write wins when both strobes are high: bit 64 follows the write strobe alone.
  assign frame   = build_frame(avs.avs_S1_write, 32'(addr_q), avs.avs_S1_writedata);

  assign tx_load  = (state_reg == IDLE) && req;
  assign tx_shift = (state_reg == LEAD) || ((state_reg == SHIFT) && (bit_cnt_reg != 7'd64));
  assign rx_shift = (state_reg == WAIT_RSP) && srdy;

  qsys_serial_shift_reg #(.WIDTH(FRAME_BITS)) u_tx (
    .clk       (clk),
    .reset     (reset),
    .load      (tx_load),
    .load_data (frame),
    .shift_en  (tx_shift),
    .ser_in    (1'b0),
    .q         (tx_q)
  );

  qsys_serial_shift_reg #(.WIDTH(RSP_BITS)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .load      (tx_load),
    .load_data ('0),
    .shift_en  (rx_shift),
    .ser_in    (sdi),
    .q         (rx_q)
  );

  // Only the transmit MSB leaves the block, and the last response bit is taken
  // straight from sdi, so these bits have no other reader.
  logic unused_bits;
  assign unused_bits = ^{tx_q[RW_BIT-1:0], rx_q[RSP_BITS-1]};

`ifdef SERIAL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             timeout_err_reg;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = TIMEOUT_CYCLES[0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      rsp_cnt_reg  <= '0;
      sle_reg      <= 1'b0;
      sdo_reg      <= 1'b0;
      is_read_reg  <= 1'b0;
      readdata_reg <= '0;
`ifdef SERIAL_TIMEOUT_EN
      tmo_cnt_reg     <= '0;
      timeout_err_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            state_reg   <= LEAD;
            sle_reg     <= 1'b1;
            sdo_reg     <= 1'b0;
            bit_cnt_reg <= '0;
            rsp_cnt_reg <= '0;
            is_read_reg <= ~avs.avs_S1_write;
          end
        end
        LEAD: begin
          sdo_reg   <= tx_q[RW_BIT];
          state_reg <= SHIFT;
        end
        SHIFT: begin
          if (bit_cnt_reg == 7'd64) begin
            state_reg <= WAIT_RSP;
            sle_reg   <= 1'b0;
            sdo_reg   <= 1'b0;
`ifdef SERIAL_TIMEOUT_EN
            tmo_cnt_reg <= '0;
`endif
          end else begin
            sdo_reg     <= tx_q[RW_BIT];
            bit_cnt_reg <= bit_cnt_reg + 7'd1;
          end
        end
        WAIT_RSP: begin
          if (srdy) begin
            rsp_cnt_reg <= rsp_cnt_reg + 5'd1;
            if (rsp_cnt_reg == 5'd31) begin
              state_reg <= DONE;
              // The shifter updates on this same edge, so fold in the final bit here.
              if (is_read_reg) begin
                readdata_reg <= {rx_q[RSP_BITS-2:0], sdi};
              end
            end
          end
`ifdef SERIAL_TIMEOUT_EN
          else if (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_reg       <= DONE;
            readdata_reg    <= TIMEOUT_DATA;
            timeout_err_reg <= 1'b1;
          end
          tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
`endif
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign avs.avs_S1_waitrequest = req && (state_reg != DONE);
  assign avs.avs_S1_readdata    = readdata_reg;
  assign sle                    = sle_reg;
  assign sdo                    = sdo_reg;
`ifdef SERIAL_TIMEOUT_EN
  assign timeout_err            = timeout_err_reg;
`endif

endmodule

// File: tb/tb_qsys_serial_initiator.sv
// Scoreboard bench for qsys_serial_initiator: a driver issues Avalon transfers, a serial
// host model checks frames and returns responses, a monitor checks each completion.
`timescale 1ns/1ps
module tb_qsys_serial_initiator;

  localparam int AW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sdo, sle;
  logic sdi = 1'b0;
  logic srdy = 1'b0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  qsys_serial_initiator_if #(.ADDR_WIDTH(AW)) avs ();

`ifdef SERIAL_TIMEOUT_EN
  logic timeout_err;
`endif

  qsys_serial_initiator #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(100)) dut (
    .clk   (clk),
    .reset (reset),
    .avs   (avs),
    .sdo   (sdo),
    .sle   (sle),
    .sdi   (sdi),
    .srdy  (srdy)
`ifdef SERIAL_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  typedef struct {
    logic [64:0] frame;
    logic [31:0] rsp;
    bit          gap;
    bit          silent;
  } host_item_t;

  typedef struct {
    logic [31:0] data;
    int          lat;
    string       name;
  } sb_item_t;

  host_item_t host_q[$];
  sb_item_t   sb_q[$];

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Serial host: samples sle/sdo on the falling edge, expects a lead 0 then 65 frame bits.
  initial begin : host
    logic [65:0] shreg;
    int hcnt;
    host_item_t hi;
    hcnt = 0;
    shreg = '0;
    forever begin
      @(negedge clk);
      if (reset || !sle) begin
        hcnt = 0;
      end else begin
        shreg = {shreg[64:0], sdo};
        hcnt++;
        if (hcnt == 66) begin
          hcnt = 0;
          if (host_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got %0h, expected no frame", shreg);
          end else begin
            hi = host_q.pop_front();
            check("frame", shreg, {1'b0, hi.frame});
            @(posedge clk);
            if (hi.silent) begin
              @(negedge clk);
              check("sle_len", 66'(sle), 66'd0);
            end else begin
              for (int i = 31; i >= 0; i--) begin
                #1 srdy = 1'b1; sdi = hi.rsp[i];
                if (i == 31) begin
                  @(negedge clk);
                  check("sle_len", 66'(sle), 66'd0);
                end
                @(posedge clk);
                if (hi.gap && i > 0) begin
                  #1 srdy = 1'b0; sdi = ~hi.rsp[i];
                  @(posedge clk);
                end
              end
            end
            #1 srdy = 1'b0; sdi = 1'b0;
          end
        end
      end
    end
  end

  initial begin : monitor
    sb_item_t it;
    forever begin
      @(negedge clk);
      if (!reset && (avs.avs_S1_read || avs.avs_S1_write) && !avs.avs_S1_waitrequest) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion: got readdata %h, expected no completion",
                   avs.avs_S1_readdata);
        end else begin
          it = sb_q.pop_front();
          check({it.name, "_rdata"}, 66'(avs.avs_S1_readdata), 66'(it.data));
          check({it.name, "_latency"}, 66'(cyc - start_cyc), 66'(it.lat));
          $display("txn %s: readdata=%h latency=%0d", it.name, avs.avs_S1_readdata,
                   cyc - start_cyc);
        end
      end
    end
  end

  task automatic txn(input string name, input bit wr, input bit rd, input logic [7:0] addr,
                     input logic [31:0] wdata, input logic [64:0] exp_frame,
                     input logic [31:0] rsp, input bit gap, input bit silent,
                     input logic [31:0] exp_rd, input int exp_lat);
    host_item_t hi;
    sb_item_t si;
    bit done;
    hi.frame = exp_frame; hi.rsp = rsp; hi.gap = gap; hi.silent = silent;
    host_q.push_back(hi);
    si.data = exp_rd; si.lat = exp_lat; si.name = name;
    sb_q.push_back(si);
    @(posedge clk);
    #1;
    avs.avs_S1_address   = addr;
    avs.avs_S1_read      = rd;
    avs.avs_S1_write     = wr;
    avs.avs_S1_writedata = wdata;
    start_cyc = cyc;
    @(negedge clk);
    check({name, "_wait_hi"}, 66'(avs.avs_S1_waitrequest), 66'd1);
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (!avs.avs_S1_waitrequest) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no completion in 400 cycles, expected waitrequest low", name);
    end
    @(posedge clk);
    #1;
    avs.avs_S1_read  = 1'b0;
    avs.avs_S1_write = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    avs.avs_S1_address   = '0;
    avs.avs_S1_read      = 1'b0;
    avs.avs_S1_write     = 1'b0;
    avs.avs_S1_writedata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sle", 66'(sle), 66'd0);
    check("rst_sdo", 66'(sdo), 66'd0);
    check("rst_rdata", 66'(avs.avs_S1_readdata), 66'd0);
    check("rst_wait", 66'(avs.avs_S1_waitrequest), 66'd0);
`ifdef SERIAL_TIMEOUT_EN
    check("rst_tmo_err", 66'(timeout_err), 66'd0);
`endif
    #1 reset = 1'b0;

    txn("wr_12", 1, 0, 8'h12, 32'hA5A5_0F0F, 65'h1_00000012_A5A50F0F,
        32'hCAFE_0000, 0, 0, 32'h0000_0000, 99);
    txn("rd_03", 0, 1, 8'h03, 32'h0, 65'h0_00000003_00000000,
        32'h1234_5678, 0, 0, 32'h1234_5678, 99);
    txn("rd_55_gap", 0, 1, 8'h55, 32'h0, 65'h0_00000055_00000000,
        32'hFFFF_0001, 1, 0, 32'hFFFF_0001, 130);

    // Abort a read in the middle of the shift phase.
    @(posedge clk);
    #1 avs.avs_S1_address = 8'h09; avs.avs_S1_read = 1'b1;
    repeat (22) @(posedge clk);
    #1 reset = 1'b1; avs.avs_S1_read = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_sle", 66'(sle), 66'd0);
    check("abort_sdo", 66'(sdo), 66'd0);
    check("abort_rdata", 66'(avs.avs_S1_readdata), 66'd0);

    txn("rd_40", 0, 1, 8'h40, 32'h0, 65'h0_00000040_00000000,
        32'h0BAD_F00D, 0, 0, 32'h0BAD_F00D, 99);
    txn("rw_7F", 1, 1, 8'h7F, 32'h0000_00C3, 65'h1_0000007F_000000C3,
        32'h5555_AAAA, 0, 0, 32'h0BAD_F00D, 99);
    txn("wr_FF", 1, 0, 8'hFF, 32'hFFFF_FFFF, 65'h1_000000FF_FFFFFFFF,
        32'h0000_0000, 0, 0, 32'h0BAD_F00D, 99);
    txn("rd_00", 0, 1, 8'h00, 32'h0, 65'h0_00000000_00000000,
        32'h8000_0001, 0, 0, 32'h8000_0001, 99);

`ifdef SERIAL_TIMEOUT_EN
    txn("rd_21_tmo", 0, 1, 8'h21, 32'h0, 65'h0_00000021_00000000,
        32'h0, 0, 1, 32'hDEAD_BEEF, 167);
    check("tmo_err_set", 66'(timeout_err), 66'd1);
    txn("rd_22", 0, 1, 8'h22, 32'h0, 65'h0_00000022_00000000,
        32'h0000_0042, 0, 0, 32'h0000_0042, 99);
    check("tmo_err_sticky", 66'(timeout_err), 66'd1);
`endif

    repeat (5) @(posedge clk);
    check("host_q_empty", 66'(host_q.size()), 66'd0);
    check("sb_q_empty", 66'(sb_q.size()), 66'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qsys_serial_initiator.md
Name: qsys_serial_initiator

Overview:
- Far end of the Qsys serial link.
- Accepts Avalon-MM slave reads and writes from a local master (CPU or Qsys fabric).
- Serialises each transaction into a 65-bit command frame on sdo/sle.
- Collects the 32-bit response from the remote serial host on sdi/srdy, then completes the Avalon transfer.
- One transaction in flight; waitrequest stalls the local master for the whole round trip.

Parameters:
- ADDR_WIDTH, 8, Avalon address width; zero-extended into frame bits 63:32.
- TIMEOUT_CYCLES, 4096, response timeout limit; used only when SERIAL_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock for Avalon and serial sides.
- reset  in  1  synchronous, active-high.
- avs_S1_address  in  ADDR_WIDTH  word address.
- avs_S1_read  in  1  read request.
- avs_S1_write  in  1  write request.
- avs_S1_writedata  in  32  write data.
- avs_S1_readdata  out  32  response data; valid when waitrequest is low during a read.
- avs_S1_waitrequest  out  1  stall.
- sdo  out  1  serial command bit; connects to the host's sdi.
- sle  out  1  frame enable; connects to the host's sle.
- sdi  in  1  serial response bit; comes from the host's sdo.
- srdy  in  1  response-bit valid; comes from the host's srdy.

Behaviour:
- Reset values (synchronous): state=IDLE, sle=0, sdo=0, avs_S1_readdata=0, counters=0. A reset mid-frame drops sle on the next edge and abandons the transaction; no Avalon completion is issued.
- Frame format, bit 64 first (MSB-first):
  - bit 64: 1=write, 0=read.
  - bits 63:32: {zeros, address}.
  - bits 31:0: writedata for a write, 0 for a read.
- avs_S1_waitrequest = (read|write) && state!=DONE, combinational. It is high from the first request cycle and low for exactly the one DONE cycle.
- If read and write are both asserted, write wins.
- State machine:
  - IDLE: on read|write, latch the frame into the 65-bit shift register, then go to LEAD.
  - LEAD: 1 cycle, sle=1, sdo=0. Gives the host time to see sle rise; this bit is not part of the frame.
  - SHIFT: 65 cycles, sle=1, sdo=frame bit 64 down to 0, one bit per clk; bit counter 0..64. After bit 0, go to WAIT_RSP with sle=0 on the next edge.
  - WAIT_RSP/CAPTURE: sle=0, sdo=0.
    - On each clk with srdy=1, shift sdi into rx[0] (rx shifts left), so the first bit lands at rx[31].
    - Count only srdy-high cycles; gaps are allowed.
    - At count 32, go to DONE.
  - DONE: 1 cycle. avs_S1_readdata=rx, waitrequest low, then go to IDLE.
- The 32-bit response is collected for writes too; for a write it is discarded and readdata keeps its previous value.
- srdy in IDLE, LEAD or SHIFT is ignored.
- Minimum latency: request at edge 0 → sle high edges 1..66 → earliest DONE at edge 67+32 when srdy is continuous from edge 67.
- Back-to-back requests: a new request is accepted in the IDLE cycle after DONE. sle is low for at least 1 cycle between frames.

Optional Feature:
- Macro: SERIAL_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT_RSP/CAPTURE and clears on entry.
  - If it reaches TIMEOUT_CYCLES before 32 srdy bits arrive, go to DONE with avs_S1_readdata=32'hDEADBEEF.
  - A sticky output `timeout_err` (out, 1) is set; it clears only on reset.
- Undefined: waits for srdy indefinitely; the `timeout_err` port is absent.

Decomposition:
- Package qsys_serial_pkg:
  - FRAME_BITS=65, RSP_BITS=32, RW_BIT=64, ADDR_MSB=63, ADDR_LSB=32.
  - State enum {IDLE, LEAD, SHIFT, WAIT_RSP, DONE}.
  - TIMEOUT_DATA=32'hDEADBEEF.
  - Shared with the serial host.
- One natural sub-module: qsys_serial_shift_reg (parameter WIDTH, parallel load, shift enable, serial in/out). Instantiate it twice: 65-bit tx and 32-bit rx.

Test Plan:
- Write addr=8'h12, data=32'hA5A5_0F0F → sle high for exactly 66 cycles; bits after the lead are 1, 24'h0, 8'h12, 32'hA5A50F0F MSB-first; waitrequest drops one cycle after the 32nd srdy bit.
- Read addr=8'h03, model returns 32'h1234_5678 with continuous srdy → readdata=32'h12345678 in the DONE cycle, exactly 99 cycles after the request.
- Read with srdy toggling 1-0 (64 cycles for 32 bits), response 32'hFFFF_0001 → correct capture; only srdy-high cycles counted.
- Reset asserted at SHIFT bit 20 → sle=0 and state IDLE on the next edge; a following read completes normally.
- read and write asserted together, addr=8'h7F → frame bit 64=1 (write wins).
- SERIAL_TIMEOUT_EN, TIMEOUT_CYCLES=100, no srdy → DONE 100 cycles after frame end; readdata=32'hDEADBEEF; timeout_err=1.
